srio_ireq_arbiter: RTL
======================

Name: srio_ireq_arbiter

Overview:
Packet-level round-robin arbiter that shares the single SRIO ireq AXI-Stream port between N_REQ requesters (type 9 data-streaming segmenter, NWRITE/NREAD engines, doorbell source, ...).
- Once granted, a requester owns the port until its tlast beat, so packets are never interleaved.
- The output is registered and feeds the SRIO core ireq interface directly.
- A beat counter cuts runaway packets that exceed the maximum legal SRIO packet length.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_BEATS, 33, maximum beats per packet (header + 256-byte payload) before a forced cut
CNT_W, 6, width of the beat counter (must hold MAX_BEATS)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
s_ireq_tvalid  in  N_REQ  per-requester valid
s_ireq_tready  out  N_REQ  per-requester ready
s_ireq_tlast  in  N_REQ  per-requester last
s_ireq_tdata  in  64*N_REQ  packed data; requester i occupies [64*i+63:64*i]
s_ireq_tkeep  in  8*N_REQ  packed keep
s_ireq_tuser  in  32*N_REQ  packed user (src/dest IDs)
ireq_tvalid  out  1  to SRIO core
ireq_tready  in  1  from SRIO core
ireq_tlast  out  1
ireq_tdata  out  64
ireq_tkeep  out  8
ireq_tuser  out  32
grant_id  out  3  index of the current or last owner
busy  out  1  high while in LOCK
err_overlong  out  1  one-cycle pulse when a packet is force-terminated

Behaviour:
- Reset (resetn=0 at a clk edge):
  - State goes to IDLE; rr_ptr=0, grant_id=0, beat_cnt=0.
  - All ireq_* outputs, s_ireq_tready, busy and err_overlong go to 0.
  - This applies even mid-packet; a partially sent packet is dropped and the SRIO core sees no further beats.
- FSM has two states, IDLE and LOCK.
- IDLE:
  - s_ireq_tready = 0.
  - If any s_ireq_tvalid bit is set, pick the first set index at or after rr_ptr, scanning upward modulo N_REQ.
  - Register that index into grant_id and go to LOCK.
  - Arbitration costs exactly one cycle; no beat is accepted in IDLE.
- LOCK:
  - s_ireq_tready[i] = (i==grant_id) && (!ireq_tvalid || ireq_tready); all other ready bits are 0.
  - An accepted beat is copied into the output register on the same edge (latency 1 cycle); beat_cnt is incremented.
  - On an accepted beat with tlast=1: go to IDLE, rr_ptr = grant_id+1 (wraps to 0 at N_REQ), beat_cnt=0.
  - On an accepted beat with beat_cnt==MAX_BEATS-1 and tlast=0: the output copy gets ireq_tlast=1, err_overlong pulses for one cycle, and the FSM goes to IDLE with rr_ptr advanced. The requester's remaining beats are later treated as a new packet.
- Output register:
  - ireq_tvalid is set on an accept.
  - It is cleared when ireq_tready=1 and there is no accept in the same cycle.
  - Data is held stable while ireq_tvalid=1 and ireq_tready=0 (AXI-S rule). The ready term above gives full throughput within a packet.
- Simultaneous events:
  - Drain and accept in the same cycle replace the register contents; ireq_tvalid stays 1.
  - A requester deasserting tvalid mid-packet keeps the lock (bubbles are allowed).
- Single-beat packet (tlast on the first beat): LOCK lasts one accept, then IDLE.
- A lone requester re-wins every arbitration. Back-to-back packets cost 1 idle input cycle between them.
- busy = (state==LOCK).
- grant_id holds its value in IDLE.
- The input tvalid/tdata of non-granted requesters are ignored.

Decomposition:
- Package srio_ireq_pkg:
  - width constants IREQ_DATA_W=64, IREQ_KEEP_W=8, IREQ_USER_W=32
  - default MAX_BEATS=33
  - state enum {ST_IDLE, ST_LOCK}
  - packed-bus slice helper
- One sub-module, srio_rr_pick: combinational N_REQ-wide rotate/priority-encode/unrotate. Inputs: req vector and rr_ptr. Outputs: gnt index and any_req.
- FSM, beat counter and output register stay in the top module.

Test Plan:
- Reset then req0 only sends a 3-beat packet (data 0xA0..0xA2, tlast on the 3rd beat) with ireq_tready=1 → ireq_tvalid starts 2 cycles after req0 tvalid rises; beats 0xA0,0xA1,0xA2; tlast on 0xA2; grant_id=0; rr_ptr becomes 1.
- req0..req3 all assert 2-beat packets continuously → grant order 0,1,2,3,0; no interleaving; exactly 1 idle input cycle between packets.
- ireq_tready toggles 1,0,0,1 during a 4-beat packet from req2 → no beat lost or duplicated; data stable while stalled; s_ireq_tready[2] low while the register is full and stalled.
- req1 sends 40 beats with no tlast → beat 33 leaves with ireq_tlast=1 and err_overlong pulses once; beats 34-40 appear as a new 7-beat packet after re-arbitration.
- resetn=0 for 1 cycle at beat 2 of a 5-beat packet → next cycle ireq_tvalid=0, busy=0, grant_id=0; req0 then wins the first arbitration.
- Single-beat packets from req3 and req1 pending simultaneously with rr_ptr=2 → req3 is granted first, then req1; each packet is one beat with tlast=1.

Source files
------------

// File: rtl/srio_ireq_arbiter_pkg.sv
// Shared constants, FSM state type and packed-bus helper for the SRIO ireq arbiter.
package srio_ireq_pkg;

    localparam int IREQ_DATA_W       = 64;
    localparam int IREQ_KEEP_W       = 8;
    localparam int IREQ_USER_W       = 32;
    localparam int MAX_BEATS_DEFAULT = 33;   // header beat + 256-byte payload
    localparam int MAX_REQ           = 8;    // widest requester count supported
    localparam int GRANT_W           = 3;    // holds an index up to MAX_REQ-1
    localparam int LANE_BUS_W        = IREQ_DATA_W * MAX_REQ;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // Extract lane idx (lane_w bits wide) from a packed bus zero-extended to
    // LANE_BUS_W; the caller truncates the result to the lane width.
    function automatic logic [IREQ_DATA_W-1:0] lane_slice(
        input logic [LANE_BUS_W-1:0] bus,
        input logic [GRANT_W-1:0]    idx,
        input int unsigned           lane_w
    );
        logic [LANE_BUS_W-1:0] shifted;
        shifted = bus >> (32'(idx) * lane_w);
        return shifted[IREQ_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/srio_ireq_arbiter_if.sv
// AXI-Stream bundle for the ireq path; LANES > 1 packs several requesters side by side.
interface srio_ireq_if #(
    parameter int LANES = 1
);
    import srio_ireq_pkg::*;

    logic [LANES-1:0]             tvalid;
    logic [LANES-1:0]             tready;
    logic [LANES-1:0]             tlast;
    logic [IREQ_DATA_W*LANES-1:0] tdata;
    logic [IREQ_KEEP_W*LANES-1:0] tkeep;
    logic [IREQ_USER_W*LANES-1:0] tuser;

    modport master (
        output tvalid, tlast, tdata, tkeep, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tlast, tdata, tkeep, tuser,
        output tready
    );

endinterface

// File: rtl/srio_ireq_arbiter_rr_pick.sv
// Round-robin pick: first requesting index at or after rr_ptr, scanning upward modulo N_REQ.
module srio_rr_pick
    import srio_ireq_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic [GRANT_W-1:0] gnt,
    output logic               any_req
);
    localparam int SUM_W = GRANT_W + 1;

    logic [MAX_REQ-1:0]  req_wide;
    logic [N_REQ-1:0]    req_rot;
    logic [GRANT_W-1:0]  idx_rot [N_REQ];

    assign req_wide = MAX_REQ'(req);

    // Rotate: position gi of req_rot is requester (rr_ptr + gi) mod N_REQ.
    // rr_ptr is always below N_REQ, so one conditional subtract is enough.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        logic [SUM_W-1:0] sum;
        assign sum          = {1'b0, rr_ptr} + SUM_W'(gi);
        assign idx_rot[gi]  = (sum >= SUM_W'(N_REQ)) ? GRANT_W'(sum - SUM_W'(N_REQ))
                                                     : GRANT_W'(sum);
        assign req_rot[gi]  = req_wide[idx_rot[gi]];
    end

    // Priority-encode the rotated vector and map back to the requester index.
    always_comb begin
        gnt = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                gnt = idx_rot[k];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/srio_ireq_arbiter.sv
// Packet-level round-robin arbiter sharing the SRIO ireq AXI-Stream port between N_REQ requesters.
module srio_ireq_arbiter
    import srio_ireq_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BEATS = MAX_BEATS_DEFAULT,
    parameter int CNT_W     = 6
) (
    input  logic               clk,
    input  logic               resetn,
    srio_ireq_if.slave         s_ireq,
    srio_ireq_if.master        ireq,
    output logic [GRANT_W-1:0] grant_id,
    output logic               busy,
    output logic               err_overlong
);
    arb_state_t             state_reg, state_next;
    logic [GRANT_W-1:0]     rr_ptr_reg, grant_id_reg, pick_idx, rr_ptr_next;
    logic [CNT_W-1:0]       beat_cnt_reg;
    logic                   any_req;

    logic                   out_valid_reg, out_last_reg, err_reg;
    logic [IREQ_DATA_W-1:0] out_data_reg;
    logic [IREQ_KEEP_W-1:0] out_keep_reg;
    logic [IREQ_USER_W-1:0] out_user_reg;

    logic [MAX_REQ-1:0]     valid_wide, last_wide;
    logic [LANE_BUS_W-1:0]  data_wide, keep_wide, user_wide;
    logic [N_REQ-1:0]       ready_onehot, s_ready;

    logic out_ready, sel_valid, sel_last, accept, cnt_at_max, pkt_end, pkt_cut;

    assign valid_wide = MAX_REQ'(s_ireq.tvalid);
    assign last_wide  = MAX_REQ'(s_ireq.tlast);
    assign data_wide  = LANE_BUS_W'(s_ireq.tdata);
    assign keep_wide  = LANE_BUS_W'(s_ireq.tkeep);
    assign user_wide  = LANE_BUS_W'(s_ireq.tuser);

    srio_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req     (s_ireq.tvalid),
        .rr_ptr  (rr_ptr_reg),
        .gnt     (pick_idx),
        .any_req (any_req)
    );

    // Output register can take a beat when empty or draining this cycle.
    assign out_ready  = !out_valid_reg || ireq.tready[0];
    assign sel_valid  = valid_wide[grant_id_reg];
    assign sel_last   = last_wide[grant_id_reg];
    assign accept     = (state_reg == ST_LOCK) && out_ready && sel_valid;
    assign cnt_at_max = (beat_cnt_reg == CNT_W'(MAX_BEATS - 1));
    assign pkt_end    = accept && (sel_last || cnt_at_max);
    assign pkt_cut    = accept && !sel_last && cnt_at_max;
    assign rr_ptr_next = (grant_id_reg == GRANT_W'(N_REQ - 1)) ? '0
                                                               : grant_id_reg + GRANT_W'(1);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign ready_onehot[gi] = (grant_id_reg == GRANT_W'(gi));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: one arbitration cycle in IDLE, hold LOCK until packet end or cut.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (any_req) state_next = ST_LOCK;
            ST_LOCK: if (pkt_end) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: only the owner sees ready, and only while in LOCK.
    always_comb begin
        busy    = 1'b0;
        s_ready = '0;
        if (state_reg == ST_LOCK) begin
            busy = 1'b1;
            if (out_ready) begin
                s_ready = ready_onehot;
            end
        end
    end

    // Grant, round-robin pointer, beat counter and overlong pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            grant_id_reg <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && any_req) begin
                grant_id_reg <= pick_idx;
            end
            if (pkt_end) begin
                rr_ptr_reg   <= rr_ptr_next;
                beat_cnt_reg <= '0;
            end else if (accept) begin
                beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            end
            err_reg <= pkt_cut;
        end
    end

    // Output beat register: load on accept, clear on drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
            out_keep_reg  <= '0;
            out_user_reg  <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_last_reg  <= sel_last || cnt_at_max;
            out_data_reg  <= lane_slice(data_wide, grant_id_reg, IREQ_DATA_W);
            out_keep_reg  <= IREQ_KEEP_W'(lane_slice(keep_wide, grant_id_reg, IREQ_KEEP_W));
            out_user_reg  <= IREQ_USER_W'(lane_slice(user_wide, grant_id_reg, IREQ_USER_W));
        end else if (ireq.tready[0]) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign s_ireq.tready = s_ready;
    assign ireq.tvalid   = out_valid_reg;
    assign ireq.tlast    = out_last_reg;
    assign ireq.tdata    = out_data_reg;
    assign ireq.tkeep    = out_keep_reg;
    assign ireq.tuser    = out_user_reg;
    assign grant_id      = grant_id_reg;
    assign err_overlong  = err_reg;

endmodule
